// File: rtl/vxe_pkg.sv
// Shared VxEngine constants used as parameter defaults across datapath units.
package vxe_pkg;

  localparam int VXE_DATA_WIDTH = 32;

endpackage

// File: rtl/vxe_data_pipe_stage.sv
// Single delay-line register: synchronous active-high clear to 0, holds when en=0.
module vxe_data_pipe_stage
  import vxe_pkg::*;
#(
  parameter int DATA_WIDTH = VXE_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Reset dominates the enable so a stalled line still clears.
  always_ff @(posedge clk) begin
    if (nrst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/vxe_data_pipe.sv
// Register delay line of NSTAGES stages with a global stall enable; NSTAGES=0 is a wire.
module vxe_data_pipe
  import vxe_pkg::*;
#(
  parameter int DATA_WIDTH = VXE_DATA_WIDTH,
  parameter int NSTAGES    = 5
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  en
);

  generate
    if (NSTAGES == 0) begin : g_pass
      // No registers exist here, so the control inputs are deliberately unused.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, nrst, en};
      assign out = in;
    end else begin : g_line
      logic [DATA_WIDTH-1:0] chain [0:NSTAGES];

      assign chain[0] = in;

      for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
        vxe_data_pipe_stage #(
          .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
          .clk (clk),
          .nrst(nrst),
          .en  (en),
          .d   (chain[g]),
          .q   (chain[g+1])
        );
      end

      assign out = chain[NSTAGES];
    end
  endgenerate

endmodule

// File: tb/tb_vxe_data_pipe.sv
// Directed bench for vxe_data_pipe: vector table on the 32x5 line plus edge-config sequences.
module tb_vxe_data_pipe;

  typedef struct {
    logic        nrst;
    logic        en;
    logic [31:0] in;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        nrst;
  logic        en;
  logic [31:0] in_main, out_main;
  logic [31:0] in_s1,   out_s1;
  logic [31:0] in_s0,   out_s0;
  logic        in_w1,   out_w1;
  logic [63:0] in_w64,  out_w64;

  int checks;
  int errors;

  vec_t vecs[$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vxe_data_pipe #(.DATA_WIDTH(32), .NSTAGES(5)) u_main (
    .clk(clk), .nrst(nrst), .in(in_main), .out(out_main), .en(en));
  vxe_data_pipe #(.DATA_WIDTH(32), .NSTAGES(1)) u_s1 (
    .clk(clk), .nrst(nrst), .in(in_s1), .out(out_s1), .en(en));
  vxe_data_pipe #(.DATA_WIDTH(32), .NSTAGES(0)) u_s0 (
    .clk(clk), .nrst(nrst), .in(in_s0), .out(out_s0), .en(en));
  vxe_data_pipe #(.DATA_WIDTH(1), .NSTAGES(5)) u_w1 (
    .clk(clk), .nrst(nrst), .in(in_w1), .out(out_w1), .en(en));
  vxe_data_pipe #(.DATA_WIDTH(64), .NSTAGES(5)) u_w64 (
    .clk(clk), .nrst(nrst), .in(in_w64), .out(out_w64), .en(en));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [31:0] d, input logic [31:0] x);
    vec_t v;
    v.nrst = r; v.en = e; v.in = d; v.exp = x;
    vecs.push_back(v);
  endtask

  // driver: apply inputs, take one edge, sample 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] hist32 [0:9];
  logic        hist1  [0:9];
  logic [63:0] hist64 [0:9];

  initial begin
    checks = 0;
    errors = 0;
    nrst = 1'b1; en = 1'b1;
    in_main = '0; in_s1 = '0; in_s0 = '0; in_w1 = 1'b0; in_w64 = '0;

    // reset held 10 edges with all-ones input, then release with zeros
    for (int i = 0; i < 10; i++) add(1, 1, 32'hFFFF_FFFF, 32'h0);
    add(0, 1, 32'h0, 32'h0);
    add(0, 1, 32'h0, 32'h0);
    // streaming: first word out on the 5th edge after sampling
    add(0, 1, 32'hBEEF_0001, 32'h0);
    add(0, 1, 32'hBEEF_0002, 32'h0);
    add(0, 1, 32'hBEEF_0003, 32'h0);
    add(0, 1, 32'hBEEF_0004, 32'h0);
    add(0, 1, 32'hBEEF_0005, 32'hBEEF_0001);
    add(0, 1, 32'hBEEF_0006, 32'hBEEF_0002);
    add(0, 1, 32'h0,         32'hBEEF_0003);
    add(0, 1, 32'h0,         32'hBEEF_0004);
    add(0, 1, 32'h0,         32'hBEEF_0005);
    add(0, 1, 32'h0,         32'hBEEF_0006);
    add(0, 1, 32'h0,         32'h0);
    // stall 3 edges before the first word emerges, then 2 more with out non-zero
    add(0, 1, 32'hBEEF_0001, 32'h0);
    add(0, 1, 32'hBEEF_0002, 32'h0);
    add(0, 1, 32'hBEEF_0003, 32'h0);
    add(0, 0, 32'hDEAD_DEAD, 32'h0);
    add(0, 0, 32'hDEAD_DEAD, 32'h0);
    add(0, 0, 32'hDEAD_DEAD, 32'h0);
    add(0, 1, 32'hBEEF_0004, 32'h0);
    add(0, 1, 32'hBEEF_0005, 32'hBEEF_0001);
    add(0, 1, 32'h0,         32'hBEEF_0002);
    add(0, 0, 32'hDEAD_DEAD, 32'hBEEF_0002);
    add(0, 0, 32'hDEAD_DEAD, 32'hBEEF_0002);
    add(0, 1, 32'h0,         32'hBEEF_0003);
    add(0, 1, 32'h0,         32'hBEEF_0004);
    add(0, 1, 32'h0,         32'hBEEF_0005);
    add(0, 1, 32'h0,         32'h0);
    // reset mid-stream with en=1, then a fresh stream
    add(0, 1, 32'hBEEF_0001, 32'h0);
    add(0, 1, 32'hBEEF_0002, 32'h0);
    add(0, 1, 32'hBEEF_0003, 32'h0);
    add(1, 1, 32'hBEEF_0004, 32'h0);
    add(0, 1, 32'hA5A5_0001, 32'h0);
    add(0, 1, 32'hA5A5_0002, 32'h0);
    add(0, 1, 32'hA5A5_0003, 32'h0);
    add(0, 1, 32'hA5A5_0004, 32'h0);
    add(0, 1, 32'hA5A5_0005, 32'hA5A5_0001);
    add(0, 1, 32'h0,         32'hA5A5_0002);
    add(0, 1, 32'h0,         32'hA5A5_0003);
    add(0, 1, 32'h0,         32'hA5A5_0004);
    add(0, 1, 32'h0,         32'hA5A5_0005);
    add(0, 1, 32'h0,         32'h0);
    // reset with en=0 while words are in flight: they must never emerge
    add(0, 1, 32'hBEEF_0001, 32'h0);
    add(0, 1, 32'hBEEF_0002, 32'h0);
    add(0, 1, 32'hBEEF_0003, 32'h0);
    add(0, 1, 32'hBEEF_0004, 32'h0);
    add(0, 1, 32'hBEEF_0005, 32'hBEEF_0001);
    add(1, 0, 32'hBEEF_0006, 32'h0);
    for (int i = 0; i < 6; i++) add(0, 1, 32'h0, 32'h0);

    foreach (vecs[i]) begin
      nrst    = vecs[i].nrst;
      en      = vecs[i].en;
      in_main = vecs[i].in;
      step();
      check($sformatf("main_v%0d", i), {32'h0, out_main}, {32'h0, vecs[i].exp});
    end

    // edge configurations and widths
    nrst = 1'b1; en = 1'b1;
    step();
    step();
    check("s1_reset", {32'h0, out_s1}, 64'h0);
    check("w64_reset", out_w64, 64'h0);
    nrst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hist32[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      hist1[i]  = (i % 2 == 0);
      hist64[i] = (i % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
      in_s1  = hist32[i];
      in_w1  = hist1[i];
      in_w64 = hist64[i];
      step();
      check($sformatf("s1_t%0d", i), {32'h0, out_s1}, {32'h0, hist32[i]});
      check($sformatf("w1_t%0d", i), {63'h0, out_w1}, (i >= 4) ? {63'h0, hist1[i-4]} : 64'h0);
      check($sformatf("w64_t%0d", i), out_w64, (i >= 4) ? hist64[i-4] : 64'h0);
    end
    en = 1'b0; in_s1 = 32'hDEAD_BEEF; in_w64 = 64'h0123_4567_89AB_CDEF;
    step();
    check("s1_stall", {32'h0, out_s1}, {32'h0, hist32[9]});
    check("w64_stall", out_w64, hist64[5]);
    en = 1'b1; in_s1 = 32'h1234_5678;
    step();
    check("s1_resume", {32'h0, out_s1}, 64'h0000_0000_1234_5678);
    check("w64_resume", out_w64, hist64[6]);

    // NSTAGES=0: combinational regardless of clock phase, reset or enable
    for (int i = 0; i < 8; i++) begin
      nrst  = i[0];
      en    = i[1];
      in_s0 = (i % 2 == 0) ? 32'hAAAA_5555 ^ 32'(i) : 32'h5A5A_0000 + 32'(i);
      #2;
      check($sformatf("s0_t%0d", i), {32'h0, out_s0}, {32'h0, in_s0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vxe_data_pipe.md
# vxe_data_pipe

Parameterized register delay line for the VxEngine datapath. It carries a data word through NSTAGES clocked stages so that a value sampled at the input appears at the output exactly NSTAGES enabled cycles later. A global enable freezes the whole line as a stall. Other VxEngine units use it to delay-match operands and side-band data against multi-cycle arithmetic.

## Interface
Parameters:
- DATA_WIDTH, 32, width of the data word in bits (≥1).
- NSTAGES, 5, number of register stages (≥0). 0 means combinational pass-through.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- nrst  input  1  reset, synchronous and active-high: 1 = reset, sampled on the rising edge of clk.
- in  input  DATA_WIDTH  data word entering stage 1.
- out  output  DATA_WIDTH  data word leaving the last stage.
- en  input  1  stage enable, 1 = advance, 0 = hold all stages.

## Operation
- Internal state: stage[1..NSTAGES], each DATA_WIDTH wide. out = stage[NSTAGES].
- On a rising edge with nrst=1: every stage is cleared to 0, regardless of en.
- On a rising edge with nrst=0 and en=1: stage[1] ← in, and stage[i] ← stage[i-1] for i = 2..NSTAGES, all simultaneously (shift).
- On a rising edge with nrst=0 and en=0: all stages hold their values, and in is ignored.
- Priority: nrst > en.
- No data transformation, no valid tracking. Every enabled cycle shifts, including zeros and "don't-care" data.
- NSTAGES=0: out = in combinationally. No registers exist, and en and nrst have no effect.
- NSTAGES=1: a single register.

## Timing
- Reset value of out: 0 (NSTAGES ≥ 1). out reads 0 from the first edge with nrst=1 until NSTAGES enabled edges after reset release.
- Latency: NSTAGES enabled clock edges. A value sampled on in at edge k, with en=1 at edges k..k+NSTAGES-1, is visible on out after edge k+NSTAGES-1 and stays until the next enabled edge.
- Throughput: one word per enabled cycle, with no bubbles inserted.
- Stall: edges with en=0 add exactly one cycle of delay per stalled edge to every word in flight. Ordering and values are preserved.
- Reset mid-stream: all in-flight words are discarded. out reads 0 after the reset edge. Words sampled after release emerge with the normal latency.
- out is purely registered (NSTAGES ≥ 1), with no combinational path from in or en.

## Structure
- Shared package `vxe_pkg`: no block-specific typedefs required. Use the package's common data-width constant as the DATA_WIDTH default where instantiated.
- One sub-module: `vxe_data_pipe_stage`, a single DATA_WIDTH register with synchronous active-high reset to 0 and a hold-enable. The top-level generate loop chains NSTAGES instances, and a generate branch handles NSTAGES=0 as a wire.

## Test plan
- Reset: hold nrst=1 for 10 cycles with in=0xFFFF_FFFF and en=1, then release with in=0 → out = 0 throughout.
- Streaming (DATA_WIDTH=32, NSTAGES=5, en=1): after reset, drive in = 0xBEEF_0001..0xBEEF_0006 on consecutive edges → out shows 0xBEEF_0001..0xBEEF_0006 on consecutive cycles, first word exactly 5 edges after it was sampled, then 0 after that (in left at 0xBEEF_0006 shows repeated 0xBEEF_0006).
- Stall: stream 0xBEEF_0001..0005, deassert en for 3 edges mid-stream → out frozen during stall, sequence resumes unchanged, each word delayed 3 extra cycles.
- Reset mid-operation: assert nrst for 1 edge while 0xBEEF_0001..0005 are in flight (en=1 or en=0) → out = 0 next cycle, no old words ever emerge, new words 0xA5A5_0001.. appear after 5 cycles.
- Edge configurations: NSTAGES=1 → out follows in one edge later. NSTAGES=0 → out == in combinationally regardless of clk/nrst/en.
- Width: DATA_WIDTH=1 and DATA_WIDTH=64 with alternating-bit patterns (0xAAAA…, 0x5555…) → bit-exact output with NSTAGES latency.
